// File: rtl/spike_rate_decoder_pkg.sv
// Shared constants and FSM state type for the spike-rate decoder.
package snn_pkg;

    localparam int SNN_NUM_CH     = 3;
    localparam int SNN_CNT_W      = 8;
    localparam int SNN_WIN_CYCLES = 256;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

endpackage

// File: rtl/spike_rate_decoder_edge_counter.sv
// Per-channel rising-edge detector with a saturating edge counter.
// count is the running total including an edge seen in the current cycle,
// so the window-end sample captures a last-cycle edge.
module spike_edge_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spike,
    input  logic             clear,
    input  logic             count_en,
    output logic [CNT_W-1:0] count
);

    logic             prev;
    logic             hit;
    logic [CNT_W-1:0] cnt_q;

    assign hit   = count_en & spike & ~prev;
    assign count = (hit && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

    // History tracks the line every cycle; the counter clears or accumulates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev  <= 1'b0;
            cnt_q <= '0;
        end else begin
            prev  <= spike;
            cnt_q <= clear ? '0 : count;
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike-rate decoder: counts rising edges per channel over a fixed window
// and publishes the counts through a valid/ready register.
// Optional macro SPIKE_EMA_EN: publish an exponential moving average of the
// window counts instead of the raw counts.
//
// state | meaning
// IDLE  | counters held at zero, waiting for ena
// COUNT | window running, edges accumulating
module spike_rate_decoder
    import snn_pkg::*;
#(
    parameter int NUM_CH     = SNN_NUM_CH,
    parameter int CNT_W      = SNN_CNT_W,
    parameter int WIN_CYCLES = SNN_WIN_CYCLES,
    parameter int EMA_SHIFT  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic [NUM_CH-1:0]       spike_in,
    output logic [NUM_CH*CNT_W-1:0] rate_data,
    output logic                    rate_valid,
    input  logic                    rate_ready,
    output logic                    window_tick,
    output logic                    overrun
);

    localparam int             WIN_W    = $clog2(WIN_CYCLES);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);

    if (WIN_CYCLES < 2 || EMA_SHIFT < 0 || EMA_SHIFT > CNT_W) begin : g_bad_params
        $error("spike_rate_decoder: WIN_CYCLES must be >= 2 and EMA_SHIFT in 0..CNT_W");
    end

    state_t                  state;
    logic [WIN_W-1:0]        win_cnt;
    logic                    run;
    logic                    win_end;
    logic [NUM_CH*CNT_W-1:0] counts;
    logic [NUM_CH*CNT_W-1:0] result;

    // Dropping ena aborts the window, so it also suppresses the tick.
    assign run         = (state == COUNT) && ena;
    assign win_end     = run && (win_cnt == WIN_LAST);
    assign window_tick = win_end;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        spike_edge_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk      (clk),
            .rst_n    (rst_n),
            .spike    (spike_in[i]),
            .clear    (~run | win_end),
            .count_en (run),
            .count    (counts[i*CNT_W +: CNT_W])
        );
    end

`ifdef SPIKE_EMA_EN
    logic [NUM_CH*CNT_W-1:0] ema_q;
    logic [NUM_CH*CNT_W-1:0] ema_next;

    // Signed difference keeps the step correct when the rate falls.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ema
        logic signed [CNT_W:0] diff;
        logic signed [CNT_W:0] step;
        assign diff = $signed({1'b0, counts[i*CNT_W +: CNT_W]})
                    - $signed({1'b0, ema_q[i*CNT_W +: CNT_W]});
        assign step = diff >>> EMA_SHIFT;
        assign ema_next[i*CNT_W +: CNT_W] =
            CNT_W'($signed({1'b0, ema_q[i*CNT_W +: CNT_W]}) + step);
    end

    // Accumulator advances on every window end, even when the publish is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ema_q <= '0;
        end else if (win_end) begin
            ema_q <= ema_next;
        end
    end

    assign result = ema_next;
`else
    assign result = counts;
`endif

    // Window FSM and window position counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            win_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    win_cnt <= '0;
                    if (ena) state <= COUNT;
                end
                COUNT: begin
                    if (!ena) begin
                        state   <= IDLE;
                        win_cnt <= '0;
                    end else if (win_cnt == WIN_LAST) begin
                        win_cnt <= '0;
                    end else begin
                        win_cnt <= win_cnt + WIN_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    win_cnt <= '0;
                end
            endcase
        end
    end

    // Publish register: a window end may load even as the old result is taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rate_data  <= '0;
            rate_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (win_end) begin
            if (!rate_valid || rate_ready) begin
                rate_data  <= result;
                rate_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (rate_valid && rate_ready) begin
            rate_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: an 8-bit and a 3-bit counter instance share
// stimulus and are checked every cycle against a behavioural model.
module tb_spike_rate_decoder;

    localparam int NCH    = 3;
    localparam int WIN    = 16;
    localparam int EMA_SH = 2;

    logic             clk;
    logic             rst_n;
    logic             ena;
    logic [NCH-1:0]   spike_in;
    logic             rate_ready;

    logic [NCH*8-1:0] data8;
    logic             valid8, tick8, over8;
    logic [NCH*3-1:0] data3;
    logic             valid3, tick3, over3;

    int checks   = 0;
    int failures = 0;

    spike_rate_decoder #(.NUM_CH(NCH), .CNT_W(8), .WIN_CYCLES(WIN), .EMA_SHIFT(EMA_SH)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .spike_in(spike_in),
        .rate_data(data8), .rate_valid(valid8), .rate_ready(rate_ready),
        .window_tick(tick8), .overrun(over8)
    );

    spike_rate_decoder #(.NUM_CH(NCH), .CNT_W(3), .WIN_CYCLES(WIN), .EMA_SHIFT(EMA_SH)) dut_s (
        .clk(clk), .rst_n(rst_n), .ena(ena), .spike_in(spike_in),
        .rate_data(data3), .rate_valid(valid3), .rate_ready(rate_ready),
        .window_tick(tick3), .overrun(over3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    bit m_act;
    int m_pos;
    int m_cnt  [NCH];
    bit m_prev [NCH];
    bit m_valid;
    bit m_over;
    int m_d8   [NCH];
    int m_d3   [NCH];
    int m_e8   [NCH];
    int m_e3   [NCH];

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic int ema(input int prev, input int c);
        int diff;
        diff = c - prev;
        return prev + (diff >>> EMA_SH);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input logic [NCH-1:0] s, input bit rd);
        bit run;
        bit tick;
        int p8 [NCH];
        int p3 [NCH];
        if (!r) begin
            m_act = 0; m_pos = 0; m_valid = 0; m_over = 0;
            for (int i = 0; i < NCH; i++) begin
                m_cnt[i] = 0; m_prev[i] = 0; m_d8[i] = 0; m_d3[i] = 0; m_e8[i] = 0; m_e3[i] = 0;
            end
            return;
        end
        run  = m_act && e;
        tick = 0;
        if (run) begin
            for (int i = 0; i < NCH; i++)
                if (s[i] && !m_prev[i]) m_cnt[i]++;
            tick  = (m_pos == WIN - 1);
            m_pos = tick ? 0 : m_pos + 1;
        end else begin
            m_pos = 0;
        end
        if (tick) begin
            for (int i = 0; i < NCH; i++) begin
                m_e8[i] = ema(m_e8[i], sat(m_cnt[i], 8));
                m_e3[i] = ema(m_e3[i], sat(m_cnt[i], 3));
`ifdef SPIKE_EMA_EN
                p8[i] = m_e8[i];
                p3[i] = m_e3[i];
`else
                p8[i] = sat(m_cnt[i], 8);
                p3[i] = sat(m_cnt[i], 3);
`endif
            end
            if (!m_valid || rd) begin
                for (int i = 0; i < NCH; i++) begin
                    m_d8[i] = p8[i];
                    m_d3[i] = p3[i];
                end
                m_valid = 1;
            end else begin
                m_over = 1;
            end
        end else if (m_valid && rd) begin
            m_valid = 0;
        end
        if (tick || !run)
            for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
        for (int i = 0; i < NCH; i++) m_prev[i] = s[i];
        m_act = e;
    endtask

    task automatic compare_all(input bit e);
        logic [NCH*8-1:0] e8;
        logic [NCH*3-1:0] e3;
        bit               etick;
        for (int i = 0; i < NCH; i++) begin
            e8[i*8 +: 8] = 8'(m_d8[i]);
            e3[i*3 +: 3] = 3'(m_d3[i]);
        end
        etick = m_act && e && (m_pos == WIN - 1);
        chk("valid8", 32'(valid8), 32'(m_valid));
        chk("data8",  32'(data8),  32'(e8));
        chk("tick8",  32'(tick8),  32'(etick));
        chk("over8",  32'(over8),  32'(m_over));
        chk("valid3", 32'(valid3), 32'(m_valid));
        chk("data3",  32'(data3),  32'(e3));
        chk("tick3",  32'(tick3),  32'(etick));
        chk("over3",  32'(over3),  32'(m_over));
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the model.
    task automatic cyc(input bit r, input bit e, input logic [NCH-1:0] s, input bit rd);
        @(negedge clk);
        rst_n = r; ena = e; spike_in = s; rate_ready = rd;
        #1;
        compare_all(e);
        model_step(r, e, s, rd);
    endtask

    logic [NCH-1:0] s;
    int ema_exp [3];

    initial begin
        rst_n = 1'b0; ena = 1'b0; spike_in = '0; rate_ready = 1'b0;
        model_step(0, 0, '0, 0);
        repeat (2) @(posedge clk);

        // Reset with toggling spikes
        cyc(0, 0, 3'b101, 0);
        cyc(0, 0, 3'b010, 0);
        cyc(1, 0, 3'b000, 0);
        chk("rst_valid", 32'(valid8), 32'd0);
        chk("rst_data",  32'(data8),  32'd0);
        chk("rst_over",  32'(over8),  32'd0);
        chk("rst_tick",  32'(tick8),  32'd0);

        // Rate count: ch0 every 4, ch1 idle, ch2 every 2
        cyc(1, 1, 3'b000, 1);
        for (int k = 0; k < WIN; k++) begin
            s = '0;
            s[0] = (k % 4 == 0);
            s[2] = (k % 2 == 0);
            cyc(1, 1, s, 1);
            if (k == WIN - 1) chk("tick_last", 32'(tick8), 32'd1);
            else if (k == WIN - 2) chk("tick_early", 32'(tick8), 32'd0);
        end

        // Level on ch1 after a low cycle; result taken on the first cycle only
        for (int k = 0; k < WIN; k++) begin
            s = '0;
            s[1] = (k != 0);
            cyc(1, 1, s, k == 0);
            if (k == 0) begin
                chk("rate_valid", 32'(valid8), 32'd1);
`ifndef SPIKE_EMA_EN
                chk("rate_data8", 32'(data8), 32'h08_00_04);
                chk("sat_data3",  32'(data3), 32'({3'd7, 3'd0, 3'd4}));
`endif
            end
        end

        // Overrun: ready low across the next window end
        for (int k = 0; k < WIN; k++) begin
            cyc(1, 1, 3'($urandom), 0);
`ifndef SPIKE_EMA_EN
            if (k == 0) chk("level_data8", 32'(data8), 32'h00_01_00);
`endif
        end
        cyc(1, 1, 3'b000, 0);
        chk("overrun_set", 32'(over8), 32'd1);
`ifndef SPIKE_EMA_EN
        chk("overrun_hold", 32'(data8), 32'h00_01_00);
`endif

        // Abort at cycle 8, then a clean window; ch2 already high when ena rises
        cyc(0, 0, 3'b000, 1);
        cyc(1, 1, 3'b000, 1);
        for (int k = 0; k < 8; k++) cyc(1, 1, (k % 2 == 0) ? 3'b001 : 3'b000, 1);
        for (int k = 0; k < 4; k++) cyc(1, 0, 3'b100 | 3'(k & 1), 1);
        cyc(1, 1, 3'b100, 1);
        for (int k = 0; k < WIN; k++) cyc(1, 1, (k % 4 == 0) ? 3'b101 : 3'b100, 1);
        cyc(1, 1, 3'b000, 1);
        chk("abort_valid", 32'(valid8), 32'd1);
`ifndef SPIKE_EMA_EN
        chk("abort_data8", 32'(data8), 32'h00_00_04);
`endif

`ifdef SPIKE_EMA_EN
        // Constant count of 8 on ch2 settles as 2, 3, 4
        ema_exp = '{2, 3, 4};
        cyc(0, 0, 3'b000, 1);
        cyc(1, 1, 3'b000, 1);
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < WIN; k++) begin
                cyc(1, 1, (k % 2 == 0) ? 3'b100 : 3'b000, 1);
                if (k == 0 && w > 0) chk("ema_seq", 32'(data8[23:16]), 32'(ema_exp[w-1]));
            end
        end
        cyc(1, 1, 3'b000, 1);
        chk("ema_seq", 32'(data8[23:16]), 32'(ema_exp[2]));
`endif

        // Randomized traffic with occasional resets and aborts
        cyc(0, 0, 3'b000, 0);
        for (int n = 0; n < 4000; n++) begin
            bit r, e, rd;
            r  = ($urandom_range(0, 499) != 0);
            e  = ($urandom_range(0, 149) != 0);
            rd = ((n / 300) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            s  = 3'($urandom) & 3'($urandom | ((n / 500) % 2 == 0 ? 0 : 32'h7));
            cyc(r, e, s, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
